// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared requester count and requester index type.
package mux_rr_arbiter_pkg;
    localparam int N_REQ = 4;
    typedef logic [1:0] req_idx_t;
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: four valid/ready requester channels plus one output channel.
// Ports: in_valid/in_data0..3/in_ready (requesters), out_valid/out_data/out_sel/out_ready (consumer).
// slave is the arbiter's view, master the producers'/consumer's view.
interface mux_rr_arbiter_if
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic [N_REQ-1:0] in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [N_REQ-1:0] in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    req_idx_t         out_sel;
    logic             out_ready;

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_rr_arbiter_mux.sv
// mux_4_1_w: WIDTH-bit 4:1 combinational mux assembled from 2-bit slices.
// Ports: d0..d3 data inputs, sel index, y selected data.
module mux_4_1_w
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  req_idx_t         sel,
    output logic [WIDTH-1:0] y
);
    for (genvar i = 0; i < WIDTH / 2; i++) begin : g_slice
        assign y[2*i +: 2] = sel[1] ? (sel[0] ? d3[2*i +: 2] : d2[2*i +: 2])
                                    : (sel[0] ? d1[2*i +: 2] : d0[2*i +: 2]);
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter steering four requesters through one 4:1 mux into a registered output.
// Ports: clk, rst (sync, active-low), bus (slave modport: requester and output channels).
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic            clk,
    input logic            rst,
    mux_rr_arbiter_if.slave bus
);
    req_idx_t         ptr_q, ptr_d, sel_q, sel_d, grant, off;
    logic             valid_q, valid_d, load, any, xfer;
    logic [WIDTH-1:0] data_q, data_d, mux_y;
    logic [3:0]       rot;

    mux_4_1_w #(.WIDTH(WIDTH)) u_mux (
        .d0  (bus.in_data0),
        .d1  (bus.in_data1),
        .d2  (bus.in_data2),
        .d3  (bus.in_data3),
        .sel (grant),
        .y   (mux_y)
    );

    // Rotate valids so bit 0 is the requester at ptr; the first set bit is the offset from ptr.
    always_comb begin
        rot     = 4'({bus.in_valid, bus.in_valid} >> ptr_q);
        off     = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
        any     = |bus.in_valid;
        grant   = ptr_q + off;
        load    = !valid_q || bus.out_ready;
        xfer    = load && any;
        valid_d = load ? any : valid_q;
        data_d  = xfer ? mux_y : data_q;
        sel_d   = xfer ? grant : sel_q;
        ptr_d   = xfer ? grant + 2'd1 : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.in_ready  = xfer ? 4'b0001 << grant : 4'b0000;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: scoreboard bench for mux_rr_arbiter.
module tb_mux_rr_arbiter;
    import mux_rr_arbiter_pkg::*;
    localparam int W = 4;

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.WIDTH(W)) bus ();
    mux_rr_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [W-1:0] d [4];
    assign bus.in_data0 = d[0];
    assign bus.in_data1 = d[1];
    assign bus.in_data2 = d[2];
    assign bus.in_data3 = d[3];

    int         checks = 0;
    int         passes = 0;
    int         ptr_m  = 0;
    logic       ov_m   = 1'b0;
    logic [1:0] hs     = '0;
    logic [W-1:0] hd   = '0;
    word_t      sb [$];

    // One cycle against the reference model; called just after a falling edge with inputs set.
    task automatic step;
        logic ld, xf;
        int g;
        logic [3:0] er;
        word_t w;
        #1;
        ld = !ov_m || bus.out_ready;
        g  = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && bus.in_valid[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
        xf = ld && (g >= 0);
        er = xf ? 4'(1 << g) : 4'b0000;
        checks++;
        if (bus.in_ready !== er) $display("FAIL in_ready: got %b want %b", bus.in_ready, er);
        else passes++;
        if (xf) sb.push_back({2'(g), d[g]});
        @(posedge clk);
        #1;
        if (xf) begin
            w     = sb.pop_front();
            hs    = w.sel;
            hd    = w.data;
            ov_m  = 1'b1;
            ptr_m = (g + 1) % 4;
        end else if (ld) ov_m = 1'b0;
        checks++;
        if (bus.out_valid !== ov_m) $display("FAIL out_valid: got %b want %b", bus.out_valid, ov_m);
        else passes++;
        if (ov_m) begin
            checks++;
            if (bus.out_sel !== hs || bus.out_data !== hd)
                $display("FAIL out_word: got sel %0d data %h want sel %0d data %h", bus.out_sel, bus.out_data, hs, hd);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_sel !== 2'd0)
                $display("FAIL reset_state: got v %b d %h s %0d want 0 0 0", bus.out_valid, bus.out_data, bus.out_sel);
            else passes++;
            @(negedge clk);
        end
        rst   = 1'b1;
        ptr_m = 0;
        ov_m  = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        apply_reset(2);
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) $display("FAIL reset_release_ready: got %b want 0001", bus.in_ready);
        else passes++;
        bus.in_valid = 4'b0000;
        step();
    endtask

    task automatic test_rotation;
        int es [5] = '{0, 1, 2, 3, 0};
        logic [W-1:0] ed [5] = '{4'ha, 4'hb, 4'hc, 4'hd, 4'ha};
        apply_reset(1);
        d[0] = 4'ha; d[1] = 4'hb; d[2] = 4'hc; d[3] = 4'hd;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.out_sel !== 2'(es[i]) || bus.out_data !== ed[i])
                $display("FAIL rotation[%0d]: got sel %0d data %h want sel %0d data %h", i, bus.out_sel, bus.out_data, es[i], ed[i]);
            else passes++;
        end
    endtask

    task automatic test_sparse;
        int es [3] = '{1, 3, 1};
        bus.in_valid = 4'b1000;
        step();
        bus.in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ((bus.in_ready & 4'b0101) !== 4'b0000) $display("FAIL sparse_idle_ready: got %b want 0 on bits 0,2", bus.in_ready);
            else passes++;
            step();
            checks++;
            if (bus.out_sel !== 2'(es[i])) $display("FAIL sparse_grant[%0d]: got %0d want %0d", i, bus.out_sel, es[i]);
            else passes++;
        end
    endtask

    task automatic test_backpressure;
        d[2] = 4'h7;
        bus.in_valid  = 4'b0100;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        repeat (3) begin
            step();
            checks++;
            if (bus.out_data !== 4'h7 || bus.out_sel !== 2'd2 || bus.out_valid !== 1'b1)
                $display("FAIL backpressure_hold: got v %b sel %0d data %h want 1 2 7", bus.out_valid, bus.out_sel, bus.out_data);
            else passes++;
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_sel !== 2'd3 || bus.out_data !== 4'hd)
            $display("FAIL backpressure_release: got sel %0d data %h want 3 d", bus.out_sel, bus.out_data);
        else passes++;
    endtask

    task automatic test_idle_drain;
        bus.in_valid  = 4'b0001;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 4'b0000;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL idle_drain: got out_valid %b want 0", bus.out_valid);
        else passes++;
        bus.in_valid = 4'b0001;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) $display("FAIL idle_lone_req: got %b want 0001", bus.in_ready);
        else passes++;
        step();
        bus.in_valid = 4'b1001;
        step();
        checks++;
        if (bus.out_sel !== 2'd3) $display("FAIL idle_wait_behind: got %0d want 3", bus.out_sel);
        else passes++;
        step();
        checks++;
        if (bus.out_sel !== 2'd0) $display("FAIL idle_then_zero: got %0d want 0", bus.out_sel);
        else passes++;
    endtask

    task automatic test_mid_reset;
        bus.in_valid  = 4'b0010;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 4'b1111;
        apply_reset(1);
        step();
        checks++;
        if (bus.out_sel !== 2'd0 || bus.out_data !== d[0])
            $display("FAIL mid_reset_first_grant: got sel %0d data %h want 0 %h", bus.out_sel, bus.out_data, d[0]);
        else passes++;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) d[k] = 4'($urandom);
            step();
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) d[k] = '0;
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_sparse();
        test_backpressure();
        test_idle_drain();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
